// File: rtl/tug_of_war_n.sv
// Tug-of-war game engine: N-LED playfield, multi-round match scoring shown on
// seven-segment digits, and an optional LFSR computer opponent on the right.
module tug_of_war_n #(
  parameter int N_LEDS    = 9,
  parameter int WIN_SCORE = 3,
  parameter int LFSR_W    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_l_n,
  input  logic              key_r_n,
  input  logic              cpu_en,
  input  logic [LFSR_W-1:0] cpu_level,
  output logic [N_LEDS-1:0] leds,
  output logic [3:0]        score_l,
  output logic [3:0]        score_r,
  output logic [6:0]        hex_l,
  output logic [6:0]        hex_r,
  output logic              match_over
);

  localparam int               POS_W   = $clog2(N_LEDS);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0] POS_CTR = POS_W'((N_LEDS - 1) / 2);
  localparam logic [3:0]       WIN     = 4'(WIN_SCORE);
  localparam logic [N_LEDS-1:0] LED_ONE = N_LEDS'(1);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    SERVE = 2'd1,
    OVER  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [3:0]         score_l_q, score_l_d;
  logic [3:0]         score_r_q, score_r_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;

  logic key_l_meta_q, key_l_sync_q, key_l_prev_q;
  logic key_r_meta_q, key_r_sync_q, key_r_prev_q;

  logic press_l, press_r, press_r_key, cpu_press;

  // Falling edge of the synchronised key: one pulse per press, however long it is held.
  assign press_l     = key_l_prev_q & ~key_l_sync_q;
  assign press_r_key = key_r_prev_q & ~key_r_sync_q;

  // LFSR x^10 + x^7 + 1; seeded non-zero so it never locks up at 0.
  assign lfsr_d    = {lfsr_q[LFSR_W-2:0], lfsr_q[9] ^ lfsr_q[6]};
  assign cpu_press = cpu_en & (lfsr_q <= cpu_level);
  assign press_r   = cpu_en ? cpu_press : press_r_key;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_l_meta_q <= 1'b1;
      key_l_sync_q <= 1'b1;
      key_l_prev_q <= 1'b1;
      key_r_meta_q <= 1'b1;
      key_r_sync_q <= 1'b1;
      key_r_prev_q <= 1'b1;
      lfsr_q       <= LFSR_W'(1);
      state_q      <= PLAY;
      pos_q        <= POS_CTR;
      score_l_q    <= 4'd0;
      score_r_q    <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // the synchroniser chain depends on it.
      key_l_meta_q <= key_l_n;
      key_l_sync_q <= key_l_meta_q;
      key_l_prev_q <= key_l_sync_q;
      key_r_meta_q <= key_r_n;
      key_r_sync_q <= key_r_meta_q;
      key_r_prev_q <= key_r_sync_q;
      lfsr_q       <= lfsr_d;
      state_q      <= state_d;
      pos_q        <= pos_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
    end
  end

  always_comb begin
    // NOTE: hold-current defaults first, so no branch can infer a latch.
    state_d   = state_q;
    pos_d     = pos_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    case (state_q)
      PLAY: begin
        if (press_l && !press_r) begin
          if (pos_q == POS_MAX) begin
            score_l_d = score_l_q + 4'd1;
            state_d   = SERVE;
          end else begin
            pos_d = pos_q + POS_W'(1);
          end
        end else if (press_r && !press_l) begin
          if (pos_q == '0) begin
            score_r_d = score_r_q + 4'd1;
            state_d   = SERVE;
          end else begin
            pos_d = pos_q - POS_W'(1);
          end
        end
      end
      SERVE: begin
        pos_d   = POS_CTR;
        state_d = (score_l_q == WIN || score_r_q == WIN) ? OVER : PLAY;
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d = PLAY;
        pos_d   = POS_CTR;
      end
    endcase
  end

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    leds = '0;
    case (state_q)
      PLAY:    leds = LED_ONE << pos_q;
      OVER:    leds = '1;
      default: leds = '0;
    endcase
  end

  assign match_over = (state_q == OVER);
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign hex_l      = seg7(score_l_q);
  assign hex_r      = seg7(score_r_q);

endmodule

// File: tb/tb_tug_of_war_n.sv
// Directed bench for tug_of_war_n (9 LEDs, 3-round match): expectations are
// queued with a due cycle when stimulus is driven and compared when that cycle arrives.
module tb_tug_of_war_n;

  localparam logic [8:0] CTR = 9'b000010000;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_l_n;
  logic       key_r_n;
  logic       cpu_en;
  logic [9:0] cpu_level;
  logic [8:0] leds;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [6:0] hex_l;
  logic [6:0] hex_r;
  logic       match_over;

  tug_of_war_n #(.N_LEDS(9), .WIN_SCORE(3), .LFSR_W(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_l_n    (key_l_n),
    .key_r_n    (key_r_n),
    .cpu_en     (cpu_en),
    .cpu_level  (cpu_level),
    .leds       (leds),
    .score_l    (score_l),
    .score_r    (score_r),
    .hex_l      (hex_l),
    .hex_r      (hex_r),
    .match_over (match_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    string      tag;
    logic [8:0] leds;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       mo;
  } exp_t;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic verify(input exp_t e);
    check({e.tag, "/leds"},       32'(leds),       32'(e.leds));
    check({e.tag, "/score_l"},    32'(score_l),    32'(e.sl));
    check({e.tag, "/score_r"},    32'(score_r),    32'(e.sr));
    check({e.tag, "/hex_l"},      32'(hex_l),      32'(seg_of(e.sl)));
    check({e.tag, "/hex_r"},      32'(hex_r),      32'(seg_of(e.sr)));
    check({e.tag, "/match_over"}, 32'(match_over), 32'(e.mo));
  endtask

  task automatic expect_at(input int dly, input string tag, input logic [8:0] l,
                           input logic [3:0] sl, input logic [3:0] sr, input logic mo);
    exp_t e;
    e.due  = cyc + dly;
    e.tag  = tag;
    e.leds = l;
    e.sl   = sl;
    e.sr   = sr;
    e.mo   = mo;
    exp_q.push_back(e);
  endtask

  // Advance n cycles; outputs are sampled on the falling edge, away from posedge.
  task automatic run(input int n);
    exp_t e;
    repeat (n) begin
      @(negedge clk);
      cyc++;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].due == cyc) begin
          e = exp_q[i];
          exp_q.delete(i);
          verify(e);
        end
      end
    end
  endtask

  task automatic press_left();
    key_l_n = 1'b0;
    run(2);
    key_l_n = 1'b1;
    run(2);
  endtask

  task automatic press_right();
    key_r_n = 1'b0;
    run(2);
    key_r_n = 1'b1;
    run(2);
  endtask

  initial begin
    reset     = 1'b1;
    key_l_n   = 1'b1;
    key_r_n   = 1'b1;
    cpu_en    = 1'b0;
    cpu_level = 10'd0;
    run(2);
    reset = 1'b0;
    expect_at(1, "reset", CTR, 4'd0, 4'd0, 1'b0);
    run(1);

    // Held key: exactly one move, landing on the third edge after sampling.
    key_l_n = 1'b0;
    expect_at(2,  "hold_wait",  CTR,          4'd0, 4'd0, 1'b0);
    expect_at(3,  "hold_move",  9'b000100000, 4'd0, 4'd0, 1'b0);
    expect_at(20, "hold_still", 9'b000100000, 4'd0, 4'd0, 1'b0);
    run(20);
    key_l_n = 1'b1;
    expect_at(3, "hold_release", 9'b000100000, 4'd0, 4'd0, 1'b0);
    run(3);

    // Simultaneous presses cancel.
    reset = 1'b1;
    run(1);
    reset   = 1'b0;
    key_l_n = 1'b0;
    key_r_n = 1'b0;
    expect_at(3, "both_a", CTR, 4'd0, 4'd0, 1'b0);
    expect_at(6, "both_b", CTR, 4'd0, 4'd0, 1'b0);
    run(6);
    key_l_n = 1'b1;
    key_r_n = 1'b1;
    expect_at(3, "both_rel", CTR, 4'd0, 4'd0, 1'b0);
    run(3);

    press_right();
    expect_at(1, "right_move", 9'b000001000, 4'd0, 4'd0, 1'b0);
    run(1);
    press_left();
    expect_at(1, "left_back", CTR, 4'd0, 4'd0, 1'b0);
    run(1);

    // Round 1: four moves to the left goal, fifth press scores.
    for (int i = 1; i <= 4; i++) begin
      press_left();
      expect_at(1, "climb", CTR << i, 4'd0, 4'd0, 1'b0);
      run(1);
    end
    expect_at(3, "goal_serve", 9'b0, 4'd1, 4'd0, 1'b0);
    expect_at(4, "goal_ctr",   CTR,  4'd1, 4'd0, 1'b0);
    press_left();

    // Rounds 2 and 3 end the match.
    for (int r = 2; r <= 3; r++) begin
      repeat (4) press_left();
      expect_at(3, "round_serve", 9'b0, 4'(r), 4'd0, 1'b0);
      if (r == 3) expect_at(4, "match_over", 9'h1FF, 4'd3, 4'd0, 1'b1);
      else        expect_at(4, "round_ctr",  CTR,    4'(r), 4'd0, 1'b0);
      press_left();
    end

    press_left();
    press_right();
    expect_at(1, "over_frozen", 9'h1FF, 4'd3, 4'd0, 1'b1);
    run(1);

    reset = 1'b1;
    expect_at(1, "reset_clear", CTR, 4'd0, 4'd0, 1'b0);
    run(1);
    reset = 1'b0;

    // Computer opponent: level 0 never presses, and the right key is ignored.
    cpu_en    = 1'b1;
    cpu_level = 10'd0;
    expect_at(1000, "cpu0_mid", CTR, 4'd0, 4'd0, 1'b0);
    expect_at(2000, "cpu0_end", CTR, 4'd0, 4'd0, 1'b0);
    run(500);
    press_right();
    run(1496);

    // Level 3FF presses every cycle: four moves then a right-goal score.
    cpu_level = 10'h3FF;
    expect_at(1, "cpu_step1", 9'b000001000, 4'd0, 4'd0, 1'b0);
    expect_at(4, "cpu_edge",  9'b000000001, 4'd0, 4'd0, 1'b0);
    expect_at(5, "cpu_score", 9'b0,         4'd0, 4'd1, 1'b0);
    run(5);
    cpu_level = 10'd0;
    expect_at(1, "cpu_serve_done", CTR, 4'd0, 4'd1, 1'b0);
    run(1);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
